// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: assembles little-endian byte pairs into
// instruction words and writes them to consecutive addresses while holding the core busy.
module imem_loader #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        len,
    input  logic              abort,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum
);

    localparam int unsigned LEN_W  = 5;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt;
    logic [LEN_W-1:0]    rem, rem_nxt;
    logic [BYTE_W-1:0]   lo_byte, lo_nxt;
    logic [BYTE_W-1:0]   hi_byte, hi_nxt;
    logic [DATA_W-1:0]   csum_nxt;
    logic                err_nxt;
    logic [DATA_W-1:0]   word;
    logic                xfer;

    logic                s_ready_nxt;
    logic                mem_we_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [DATA_W-1:0]   mem_wdata_nxt;
    logic                busy_nxt;
    logic                done_nxt;

    // State register plus registered outputs, all cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            addr      <= '0;
            rem       <= '0;
            lo_byte   <= '0;
            hi_byte   <= '0;
            checksum  <= '0;
            err       <= 1'b0;
            s_ready   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            rem       <= rem_nxt;
            lo_byte   <= lo_nxt;
            hi_byte   <= hi_nxt;
            checksum  <= csum_nxt;
            err       <= err_nxt;
            s_ready   <= s_ready_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        rem_nxt       = rem;
        lo_nxt        = lo_byte;
        hi_nxt        = hi_byte;
        csum_nxt      = checksum;
        err_nxt       = err;
        word          = DATA_W'({hi_byte, lo_byte});
        xfer          = s_valid && s_ready;
        s_ready_nxt   = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = '0;
        mem_wdata_nxt = '0;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len > LEN_W'(DEPTH)) begin
                        // Oversized request is rejected without touching load state
                        err_nxt = 1'b1;
                    end else begin
                        addr_nxt  = '0;
                        rem_nxt   = len;
                        csum_nxt  = '0;
                        err_nxt   = 1'b0;
                        state_nxt = (len == '0) ? S_DONE : S_LO;
                    end
                end
            end
            S_LO: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    err_nxt   = 1'b1;
                    lo_nxt    = '0;
                    hi_nxt    = '0;
                end else if (xfer) begin
                    lo_nxt    = s_data;
                    state_nxt = S_HI;
                end
            end
            S_HI: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    err_nxt   = 1'b1;
                    lo_nxt    = '0;
                    hi_nxt    = '0;
                end else if (xfer) begin
                    hi_nxt    = s_data;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                // The write in flight always completes; abort only redirects afterwards
                csum_nxt = checksum ^ word;
                addr_nxt = addr + ADDR_W'(1);
                rem_nxt  = rem - LEN_W'(1);
                if (abort) begin
                    state_nxt = S_IDLE;
                    err_nxt   = 1'b1;
                end else if (rem == LEN_W'(1)) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_LO;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        s_ready_nxt = (state_nxt == S_LO) || (state_nxt == S_HI);
        busy_nxt    = (state_nxt == S_LO) || (state_nxt == S_HI) || (state_nxt == S_WRITE);
        done_nxt    = (state_nxt == S_DONE);
        if (state_nxt == S_WRITE) begin
            mem_we_nxt    = 1'b1;
            mem_addr_nxt  = addr_nxt;
            mem_wdata_nxt = DATA_W'({hi_nxt, lo_nxt});
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with a write/done/busy monitor.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  len;
    logic        abort;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] checksum;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt;
    int done_cyc;
    int busy_cnt;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    imem_loader #(.DEPTH(16), .ADDR_W(4), .DATA_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(32'(mem_addr));
            wr_data.push_back(32'(mem_wdata));
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
        busy_cnt = 0;
        done_cyc = 0;
    endtask

    task automatic do_start(input logic [4:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        ok      = 1'b0;
        s_data  = b;
        s_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (s_ready) ok = 1'b1;
            tick();
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_write(input int idx, input logic [31:0] a, input logic [31:0] d);
        if (wr_addr.size() > idx) begin
            check("wr_addr", wr_addr[idx], a);
            check("wr_data", wr_data[idx], d);
        end else begin
            check("wr_missing", 32'(wr_addr.size()), 32'(idx + 1));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_checksum"}, 32'(checksum), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int idx;
        logic acc;
        logic [7:0] tb_bytes[2];

        reset = 1'b1; start = 1'b0; len = '0; abort = 1'b0; s_data = '0; s_valid = 1'b0;
        clear_mon();
        tick(); tick();
        check_all_zero("rst");
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // len=2 basic load with timing
        clear_mon();
        s0 = cyc;
        do_start(5'd2);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h37); send_byte(8'h12);
        s_valid = 1'b0;
        repeat (3) tick();
        check("l2_nwr", 32'(wr_addr.size()), 32'd2);
        check_write(0, 32'h0, 32'h0013);
        check_write(1, 32'h1, 32'h1237);
        check("l2_csum", 32'(checksum), 32'h1224);
        check("l2_done_cnt", 32'(done_cnt), 32'd1);
        check("l2_done_cyc", 32'(done_cyc - s0), 32'd7);
        check("l2_busy_cnt", 32'(busy_cnt), 32'd6);
        check("l2_err", 32'(err), 32'd0);

        // full-depth load
        clear_mon();
        do_start(5'd16);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i));
            send_byte(8'h00);
        end
        s_valid = 1'b0;
        repeat (3) tick();
        check("l16_nwr", 32'(wr_addr.size()), 32'd16);
        for (int i = 0; i < 16; i++) check_write(i, 32'(i), 32'(i));
        check("l16_csum", 32'(checksum), 32'h0000);
        check("l16_done_cnt", 32'(done_cnt), 32'd1);

        // oversized length rejected
        clear_mon();
        do_start(5'd17);
        repeat (3) tick();
        check("l17_err", 32'(err), 32'd1);
        check("l17_busy_cnt", 32'(busy_cnt), 32'd0);
        check("l17_nwr", 32'(wr_addr.size()), 32'd0);
        check("l17_done_cnt", 32'(done_cnt), 32'd0);

        // zero length completes immediately and clears err
        clear_mon();
        do_start(5'd0);
        check("l0_done", 32'(done), 32'd1);
        check("l0_err", 32'(err), 32'd0);
        tick();
        check("l0_done_off", 32'(done), 32'd0);
        check("l0_nwr", 32'(wr_addr.size()), 32'd0);
        check("l0_done_cnt", 32'(done_cnt), 32'd1);

        // s_valid toggling
        clear_mon();
        tb_bytes[0] = 8'hEF;
        tb_bytes[1] = 8'hBE;
        do_start(5'd1);
        idx = 0;
        for (int c = 0; c < 30 && idx < 2; c++) begin
            s_valid = (c % 2 == 0);
            s_data  = tb_bytes[idx];
            acc     = s_valid && s_ready;
            tick();
            if (acc) idx++;
        end
        s_valid = 1'b0;
        repeat (3) tick();
        check("tog_bytes", 32'(idx), 32'd2);
        check("tog_nwr", 32'(wr_addr.size()), 32'd1);
        check_write(0, 32'h0, 32'hBEEF);
        check("tog_csum", 32'(checksum), 32'hBEEF);
        check("tog_done_cnt", 32'(done_cnt), 32'd1);

        // abort in HI, then recovery with start+abort together
        clear_mon();
        do_start(5'd1);
        send_byte(8'hAA);
        s_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abh_busy", 32'(busy), 32'd0);
        check("abh_err", 32'(err), 32'd1);
        check("abh_ready", 32'(s_ready), 32'd0);
        repeat (2) tick();
        check("abh_nwr", 32'(wr_addr.size()), 32'd0);
        check("abh_done_cnt", 32'(done_cnt), 32'd0);
        clear_mon();
        abort = 1'b1;
        do_start(5'd1);
        abort = 1'b0;
        check("rec_busy", 32'(busy), 32'd1);
        check("rec_err", 32'(err), 32'd0);
        send_byte(8'h5A); send_byte(8'hC3);
        s_valid = 1'b0;
        repeat (3) tick();
        check("rec_nwr", 32'(wr_addr.size()), 32'd1);
        check_write(0, 32'h0, 32'hC35A);
        check("rec_done_cnt", 32'(done_cnt), 32'd1);

        // abort in WRITE lets the write finish, no done
        clear_mon();
        do_start(5'd2);
        send_byte(8'h01); send_byte(8'h02);
        s_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abw_busy", 32'(busy), 32'd0);
        check("abw_err", 32'(err), 32'd1);
        repeat (3) tick();
        check("abw_nwr", 32'(wr_addr.size()), 32'd1);
        check_write(0, 32'h0, 32'h0201);
        check("abw_csum", 32'(checksum), 32'h0201);
        check("abw_done_cnt", 32'(done_cnt), 32'd0);

        // reset in HI mid-load
        clear_mon();
        do_start(5'd3);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        check("mid_csum", 32'(checksum), 32'h2211);
        reset = 1'b1;
        #1;
        check_all_zero("mrst");
        s_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("mrst_nwr", 32'(wr_addr.size()), 32'd1);
        check("mrst_done_cnt", 32'(done_cnt), 32'd0);
        clear_mon();
        do_start(5'd1);
        send_byte(8'h66); send_byte(8'h77);
        s_valid = 1'b0;
        repeat (3) tick();
        check("post_nwr", 32'(wr_addr.size()), 32'd1);
        check_write(0, 32'h0, 32'h7766);
        check("post_done_cnt", 32'(done_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
